// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter response return path.
package arb_pkg;

  // Widest requester vector the one-hot decoder accepts.
  localparam int MAX_REQ   = 64;
  localparam int MAX_IDX_W = 6;

  typedef logic [MAX_IDX_W-1:0] req_idx_t;

  typedef struct packed {
    req_idx_t idx;
    logic     is_onehot;
  } onehot_dec_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Returns the index of the highest set bit and whether exactly one bit is set.
  function automatic onehot_dec_t onehot_to_idx(input logic [MAX_REQ-1:0] vec);
    onehot_dec_t r;
    int          ones;
    r.idx = '0;
    ones  = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) begin
        r.idx = req_idx_t'(i);
        ones++;
      end
    end
    r.is_onehot = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO holding the owner of each outstanding grant.
module arb_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // No bypass in either direction: a full FIFO refuses pushes even while popping,
  // and an empty FIFO has nothing to pop even while pushing.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; only the pointers define
  // which entries are live, so clearing the array would just cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_response_router.sv
// Records arbiter grants in order and steers each shared-resource response
// back to the requester that owns it.
module arb_response_router
  import arb_pkg::*;
#(
  parameter int N_REQ   = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       grant_valid,
  input  logic [N_REQ-1:0]           grant_onehot,
  output logic                       grant_ready,
  input  logic                       rsp_valid,
  input  logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_ready,
  output logic [N_REQ-1:0]           out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic [N_REQ-1:0]           out_ready,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  input  logic                       err_clr,
  output logic                       err_multi_grant,
  output logic                       err_orphan_rsp
);

  localparam int IDX_W = idx_width(N_REQ);

  logic [MAX_REQ-1:0] grant_wide;
  onehot_dec_t        dec;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant_fire;
  logic               push;
  logic               pop;
  logic               multi_now;
  logic               orphan_now;

  assign grant_wide = MAX_REQ'(grant_onehot);
  assign dec        = onehot_to_idx(grant_wide);
  assign grant_idx  = IDX_W'(dec.idx);

  assign grant_ready = !fifo_full;
  assign grant_fire  = grant_valid && grant_ready;
  assign push        = grant_fire && dec.is_onehot;
  assign pop         = rsp_valid && rsp_ready;

  arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // NOTE: every output of this block gets a default before the conditional
  // override, so no path leaves out_valid unassigned and no latch is inferred.
  always_comb begin
    out_valid = '0;
    rsp_ready = 1'b0;
    if (!fifo_empty) begin
      out_valid[head] = rsp_valid;
      rsp_ready       = out_ready[head];
    end
  end

  assign out_data = rsp_data;

  assign multi_now  = grant_fire && !dec.is_onehot;
  assign orphan_now = rsp_valid && fifo_empty;

  // A new error outranks err_clr for that flag in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_multi_grant <= 1'b0;
      err_orphan_rsp  <= 1'b0;
    end else begin
      if (multi_now)    err_multi_grant <= 1'b1;
      else if (err_clr) err_multi_grant <= 1'b0;
      if (orphan_now)   err_orphan_rsp  <= 1'b1;
      else if (err_clr) err_orphan_rsp  <= 1'b0;
    end
  end

  a_out_valid_onehot0 : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(out_valid)
  );

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) outstanding <= ($clog2(MAX_OUT) + 1)'(MAX_OUT)
  );

endmodule

// File: tb/tb_arb_response_router.sv
// Random plus directed bench for arb_response_router against a queue-based model.
module tb_arb_response_router;

  localparam int N_REQ   = 8;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              grant_valid;
  logic [N_REQ-1:0]  grant_onehot;
  logic              grant_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic [N_REQ-1:0]  out_valid;
  logic [DATA_W-1:0] out_data;
  logic [N_REQ-1:0]  out_ready;
  logic [CNT_W-1:0]  outstanding;
  logic              err_clr;
  logic              err_multi_grant;
  logic              err_orphan_rsp;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the list of owners awaiting a response, oldest first.
  int q[$];
  bit m_err_multi;
  bit m_err_orphan;
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  arb_response_router #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .grant_valid     (grant_valid),
    .grant_onehot    (grant_onehot),
    .grant_ready     (grant_ready),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_ready       (rsp_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .outstanding     (outstanding),
    .err_clr         (err_clr),
    .err_multi_grant (err_multi_grant),
    .err_orphan_rsp  (err_orphan_rsp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err_multi  = 1'b0;
      m_err_orphan = 1'b0;
      model_live   = 1'b1;
    end else if (model_live) begin
      bit g_fire, r_fire, new_multi, new_orphan;
      int idx;
      g_fire     = grant_valid && (q.size() < MAX_OUT);
      r_fire     = rsp_valid && (q.size() > 0) && out_ready[q[0]];
      new_multi  = g_fire && ($countones(grant_onehot) != 1);
      new_orphan = rsp_valid && (q.size() == 0);
      if (r_fire) void'(q.pop_front());
      if (g_fire && $countones(grant_onehot) == 1) begin
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (grant_onehot[i]) idx = i;
        q.push_back(idx);
      end
      if (new_multi)    m_err_multi  = 1'b1;
      else if (err_clr) m_err_multi  = 1'b0;
      if (new_orphan)   m_err_orphan = 1'b1;
      else if (err_clr) m_err_orphan = 1'b0;
    end
  end

  // Compare process: mid-cycle, outputs settle from state plus current inputs.
  always @(negedge clk) begin
    if (model_live) begin
      logic [N_REQ-1:0] exp_valid;
      logic             exp_ready;
      exp_valid = '0;
      exp_ready = 1'b0;
      if (q.size() > 0) begin
        exp_valid[q[0]] = rsp_valid;
        exp_ready       = out_ready[q[0]];
      end
      check("grant_ready", 64'(grant_ready), 64'(q.size() < MAX_OUT));
      check("outstanding", 64'(outstanding), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("rsp_ready", 64'(rsp_ready), 64'(exp_ready));
      check("err_multi_grant", 64'(err_multi_grant), 64'(m_err_multi));
      check("err_orphan_rsp", 64'(err_orphan_rsp), 64'(m_err_orphan));
      if (q.size() > 0) check("out_data", 64'(out_data), 64'(rsp_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    grant_valid  = 1'b0;
    grant_onehot = '0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    out_ready    = '0;
    err_clr      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("lit_reset_outstanding", 64'(outstanding), 64'd0);
    check("lit_reset_grant_ready", 64'(grant_ready), 64'd1);
    check("lit_reset_rsp_ready", 64'(rsp_ready), 64'd0);
    check("lit_reset_out_valid", 64'(out_valid), 64'd0);

    // In-order routing of three grants.
    grant_valid = 1'b1;
    grant_onehot = 8'h04; step(); check("lit_t1_out1", 64'(outstanding), 64'd1);
    grant_onehot = 8'h01; step(); check("lit_t1_out2", 64'(outstanding), 64'd2);
    grant_onehot = 8'h80; step(); check("lit_t1_out3", 64'(outstanding), 64'd3);
    idle();
    rsp_valid = 1'b1; out_ready = '1;
    rsp_data = 32'hA; #1;
    check("lit_t1_valid_a", 64'(out_valid), 64'h04);
    check("lit_t1_data_a", 64'(out_data), 64'hA);
    step(); check("lit_t1_out_after_a", 64'(outstanding), 64'd2);
    rsp_data = 32'hB; #1;
    check("lit_t1_valid_b", 64'(out_valid), 64'h01);
    step(); check("lit_t1_out_after_b", 64'(outstanding), 64'd1);
    rsp_data = 32'hC; #1;
    check("lit_t1_valid_c", 64'(out_valid), 64'h80);
    step(); check("lit_t1_out_after_c", 64'(outstanding), 64'd0);

    // Fill to MAX_OUT, then a held fifth grant.
    idle();
    grant_valid = 1'b1;
    for (int i = 0; i < MAX_OUT; i++) begin
      grant_onehot = N_REQ'(1) << i;
      step();
    end
    check("lit_t2_full_count", 64'(outstanding), 64'd4);
    check("lit_t2_full_ready", 64'(grant_ready), 64'd0);
    grant_onehot = 8'h10; step();
    check("lit_t2_held_count", 64'(outstanding), 64'd4);
    grant_valid = 1'b0;
    rsp_valid = 1'b1; out_ready = '1; step();
    rsp_valid = 1'b0; #1;
    check("lit_t2_ready_back", 64'(grant_ready), 64'd1);
    rsp_valid = 1'b1; step();

    // Backpressure on head tag 2.
    out_ready = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lit_t3_bp_ready", 64'(rsp_ready), 64'd0);
      check("lit_t3_bp_valid", 64'(out_valid), 64'h04);
      step();
    end
    out_ready = 8'h04; step();
    rsp_valid = 1'b0; #1;
    check("lit_t3_after_fire", 64'(outstanding), 64'd1);

    // Non-one-hot grant.
    idle();
    grant_valid = 1'b1; grant_onehot = 8'h06; step();
    idle(); #1;
    check("lit_t4_multi_set", 64'(err_multi_grant), 64'd1);
    check("lit_t4_count_same", 64'(outstanding), 64'd1);
    err_clr = 1'b1; step();
    err_clr = 1'b0; #1;
    check("lit_t4_multi_clr", 64'(err_multi_grant), 64'd0);

    // Drain, then an orphan response.
    rsp_valid = 1'b1; out_ready = '1; step();
    #1;
    check("lit_t5_orphan_ready", 64'(rsp_ready), 64'd0);
    check("lit_t5_orphan_valid", 64'(out_valid), 64'd0);
    step();
    idle(); #1;
    check("lit_t5_orphan_flag", 64'(err_orphan_rsp), 64'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Simultaneous enqueue and dequeue, then reset mid-operation.
    grant_valid = 1'b1;
    grant_onehot = 8'h01; step();
    grant_onehot = 8'h02; step();
    grant_onehot = 8'h10; rsp_valid = 1'b1; out_ready = '1; step();
    grant_valid = 1'b0; #1;
    check("lit_t6_count_same", 64'(outstanding), 64'd2);
    check("lit_t6_head_1", 64'(out_valid), 64'h02);
    step(); #1;
    check("lit_t6_head_4", 64'(out_valid), 64'h10);
    rst_n = 1'b0; step();
    rst_n = 1'b1; #1;
    check("lit_t6_rst_count", 64'(outstanding), 64'd0);
    check("lit_t6_rst_ready", 64'(rsp_ready), 64'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      grant_valid  = ($urandom_range(0, 1) == 1);
      grant_onehot = (r < N_REQ) ? N_REQ'(1) << r : N_REQ'($urandom);
      rsp_valid    = ($urandom_range(0, 2) != 0);
      rsp_data     = $urandom;
      out_ready    = N_REQ'($urandom) | N_REQ'($urandom);
      err_clr      = ($urandom_range(0, 19) == 0);
      rst_n        = ($urandom_range(0, 149) != 0);
      step();
    end
    idle();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
